hnf_txreq_sched: RTL and testbench
==================================

# hnf_txreq_sched

Home-node (HNF) scheduler that shares the single CHI TXREQ channel toward the SNF between several internal request sources (e.g. read-miss, writeback, prefetch). It arbitrates among requesters, tracks CHI link-layer credits received on `txreqlcrdv`, and registers the winning flit onto `txreqflit`/`txreqflitv`. No flit is sent without a held credit.

## Interface
- `NUM_REQ`, default 4: number of internal requesters; legal range 2..8.
- `MAX_CRD`, default 15: maximum L-credits held, per the CHI limit; counter width is `$clog2(MAX_CRD+1)`.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i holds a flit.
- `req_flit`  in  NUM_REQ x reqflit_t  flit per requester; must be stable while `req_valid` is high.
- `req_ready`  out  NUM_REQ  one-hot grant; the flit is accepted when `req_valid[i] & req_ready[i]`.
- `txreqflit`  out  reqflit_t  registered flit to SNF.
- `txreqflitv`  out  1  flit valid, one cycle per flit.
- `txreqflitpend`  out  1  flit-pending indicator.
- `txreqlcrdv`  in  1  one L-credit returned per cycle when high.
- `crd_cnt`  out  CW  current credit count, for debug/perf.
- `crd_ovf`  out  1  sticky error: a credit arrived while already at `MAX_CRD`.

## Operation
- Credit counter `crd_cnt`:
  - +1 when `txreqlcrdv`.
  - -1 on acceptance.
  - Both in the same cycle: unchanged.
  - At `MAX_CRD`, a `txreqlcrdv` without a same-cycle acceptance sets `crd_ovf` and leaves the counter saturated.
  - The counter never goes below 0.
- Eligibility: grants are issued only when the registered `crd_cnt != 0`. A credit arriving in cycle t is not usable until t+1; there is no bypass.
- Arbitration:
  - `req_ready` is all-zero when there is no credit or no `req_valid`.
  - Otherwise exactly one bit is set: the first valid requester at or after the round-robin pointer `rr_ptr`.
  - `req_ready` depends only on current `req_valid`, `rr_ptr` and `crd_cnt`; it has no dependency on `txreqlcrdv`.
- Pointer: on acceptance by requester i, `rr_ptr <= (i+1) mod NUM_REQ`. There is no pointer update when nothing is accepted.
- Output register:
  - On acceptance, `txreqflit <= req_flit[i]` and `txreqflitv <= 1`.
  - Otherwise `txreqflitv <= 0`, and `txreqflit` holds its last value.
- `txreqflitpend = |req_valid` (combinational). Because acceptance in cycle t yields `txreqflitv` in t+1, pend always precedes valid by at least one cycle.
- Throughput: one flit per cycle while credits last. Back-to-back flits from different requesters are allowed.

## Timing
- Reset values:
  - `txreqflitv`=0, `txreqflit`=0, `crd_cnt`=0, `rr_ptr`=0, `crd_ovf`=0.
  - `req_ready`=0, because the count is 0.
- Latency from acceptance (cycle t) to `txreqflitv` is exactly 1 cycle (t+1).
- Latency from a credit at t to the earliest possible grant is t+1.
- Reset mid-operation: the registered flit is dropped and all held credits are discarded (link re-handshake is assumed by protocol). `crd_ovf` clears.
- Full (`crd_cnt==MAX_CRD`) with a simultaneous credit and acceptance: count stays at `MAX_CRD` and no overflow is flagged.
- Empty (`crd_cnt==0`) with a simultaneous credit: no grant that cycle; count becomes 1.
- Single valid requester: it wins regardless of `rr_ptr`.

## Configuration
- `HNF_TXREQ_QOS_EN` defined:
  - Eligible requesters are first filtered to those with the maximum `req_flit[i].QoS`.
  - Round-robin from `rr_ptr` applies among that subset.
  - Pointer update is unchanged.
- `HNF_TXREQ_QOS_EN` undefined: pure round-robin; QoS is ignored for arbitration but still passed through in the flit.

## Structure
- `reqflit_t` comes from `chi_flit.vh`.
- `HNF_TXREQ_NUM_REQ` and `CHI_MAX_LCRD` (=15) are added to the shared HNF package; the parameter defaults take these values.
- One sub-module: `hnf_rr_arb`, a parameterised round-robin arbiter.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and grant index.
  - The QoS filter lives in `hnf_txreq_sched` ahead of it.

## Test plan
- Reset, then 3 credits; requesters 0 and 2 both valid continuously. Expected: grants 0, 2, 0, each `txreqflitv` one cycle after its grant, then `req_ready`=0 with `crd_cnt`=0.
- `crd_cnt`=0, requester 1 valid, credit at cycle 10. Expected: grant at 11, `txreqflitv` at 12 carrying the requester-1 TxnID, `txreqflitpend` high from first request.
- Fill to 15 credits, then drive `txreqlcrdv` with no request. Expected: `crd_ovf`=1 (sticky), `crd_cnt`=15. In a separate run, drive a credit and an acceptance in the same cycle at 15. Expected: count 15, no overflow.
- With `HNF_TXREQ_QOS_EN`: requesters 0/1/3 at QoS 2/9/9, `rr_ptr`=0, 2 credits. Expected: grants 1 then 3.
- Reset asserted in the cycle after an acceptance with `crd_cnt`=5. Expected: next cycle `txreqflitv`=0 and `crd_cnt`=0, with no grants until a new credit arrives.
- All `NUM_REQ` requesters valid with ample credits for 8 cycles. Expected: grant order 0, 1, 2, 3, 0, 1, 2, 3 and `txreqflitv` continuously high from cycle 2.

Source files
------------

// File: rtl/hnf_txreq_sched_pkg.sv
// Shared HNF definitions for the TXREQ scheduler: requester count, CHI L-credit limit and the request flit.
// The optional QoS pre-filter is enabled by defining HNF_TXREQ_QOS_EN.
package hnf_txreq_sched_pkg;

    localparam int HNF_TXREQ_NUM_REQ = 4;
    localparam int CHI_MAX_LCRD      = 15;

    typedef logic [3:0] qos_t;

    typedef struct packed {
        qos_t        qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [5:0]  opcode;
        logic [47:0] addr;
    } reqflit_t;

    // Round-robin successor of a granted index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hnf_txreq_sched_if.sv
// Bundle of requester handshakes, the TXREQ link toward the SNF and the credit debug outputs.
interface hnf_txreq_sched_if
    import hnf_txreq_sched_pkg::*;
#(
    parameter int NUM_REQ = HNF_TXREQ_NUM_REQ,
    parameter int MAX_CRD = CHI_MAX_LCRD
) ();

    localparam int CW = $clog2(MAX_CRD + 1);

    logic [NUM_REQ-1:0] req_valid;
    reqflit_t           req_flit [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    reqflit_t           txreqflit;
    logic               txreqflitv;
    logic               txreqflitpend;
    logic               txreqlcrdv;
    logic [CW-1:0]      crd_cnt;
    logic               crd_ovf;

    // Requesters and SNF credit return side.
    modport master (
        output req_valid, req_flit, txreqlcrdv,
        input  req_ready, txreqflit, txreqflitv, txreqflitpend, crd_cnt, crd_ovf
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_flit, txreqlcrdv,
        output req_ready, txreqflit, txreqflitv, txreqflitpend, crd_cnt, crd_ovf
    );

endinterface

// File: rtl/hnf_rr_arb.sv
// Parameterised round-robin arbiter: grants the first request at or after ptr when enabled.
module hnf_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic          found;
    int            j;
    logic [PW-1:0] jj;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = PW'(j);
            if (en && !found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                gnt_idx = jj;
            end
        end
    end

endmodule

// File: rtl/hnf_txreq_sched.sv
// HNF TXREQ scheduler: credit-gated round-robin sharing of the CHI TXREQ channel toward the SNF.
// Define HNF_TXREQ_QOS_EN to restrict arbitration to the requesters carrying the highest QoS.
module hnf_txreq_sched
    import hnf_txreq_sched_pkg::*;
#(
    parameter int NUM_REQ = HNF_TXREQ_NUM_REQ,
    parameter int MAX_CRD = CHI_MAX_LCRD
) (
    input logic              clock,
    input logic              reset,
    hnf_txreq_sched_if.slave bus
);

    localparam int CW = $clog2(MAX_CRD + 1);
    localparam int PW = $clog2(NUM_REQ);

    // Handshake: requester i hands over req_flit[i] in the cycle where req_valid[i] & req_ready[i];
    // req_flit[i] must stay stable while req_valid[i] is high, and req_ready never looks at req_flit
    // except for QoS ranking nor at txreqlcrdv, so a credit only becomes usable one cycle later.

    logic [CW-1:0]      crd_q;
    logic               ovf_q;
    logic [PW-1:0]      rr_ptr;
    reqflit_t           flit_q;
    logic               flitv_q;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               crd_avail;
    logic               accept;

    assign crd_avail = (crd_q != '0);

`ifdef HNF_TXREQ_QOS_EN
    qos_t max_qos;

    always_comb begin
        max_qos = '0;
        elig    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && (bus.req_flit[i].qos > max_qos)) max_qos = bus.req_flit[i].qos;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] && (bus.req_flit[i].qos == max_qos);
        end
    end
`else
    assign elig = bus.req_valid;
`endif

    hnf_rr_arb #(.N(NUM_REQ)) u_arb (
        .req     (elig),
        .en      (crd_avail),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are a subset of valid requesters, so any grant is an acceptance.
    assign accept = |gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            crd_q   <= '0;
            ovf_q   <= 1'b0;
            rr_ptr  <= '0;
            flit_q  <= '0;
            flitv_q <= 1'b0;
        end else begin
            flitv_q <= accept;
            if (accept) begin
                flit_q <= bus.req_flit[gnt_idx];
                rr_ptr <= PW'(rr_next(int'(gnt_idx), NUM_REQ));
            end
            case ({bus.txreqlcrdv, accept})
                2'b10: begin
                    if (crd_q == CW'(MAX_CRD)) ovf_q <= 1'b1;
                    else                       crd_q <= crd_q + CW'(1);
                end
                2'b01:   crd_q <= crd_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = gnt;
    assign bus.txreqflit     = flit_q;
    assign bus.txreqflitv    = flitv_q;
    assign bus.txreqflitpend = |bus.req_valid;
    assign bus.crd_cnt       = crd_q;
    assign bus.crd_ovf       = ovf_q;

endmodule

// File: tb/tb_hnf_txreq_sched.sv
// Bench for hnf_txreq_sched: scenario tasks with inline checks plus a flit scoreboard on txreqflit.
module tb_hnf_txreq_sched;
    import hnf_txreq_sched_pkg::*;

    localparam int W = $bits(reqflit_t);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hnf_txreq_sched_if #(.NUM_REQ(4), .MAX_CRD(15)) bus ();

    hnf_txreq_sched #(.NUM_REQ(4), .MAX_CRD(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    logic           mon_en   = 1'b0;
    reqflit_t       flits [4];
    logic [W-1:0]   exp_q [$];
    int             due_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: each expected flit must appear exactly on its due cycle, in order.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.txreqflitv === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got flit %h at cycle %0d, want no flit", bus.txreqflit, cyc);
                end else begin
                    logic [W-1:0] f;
                    int           d;
                    f = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (bus.txreqflit !== f || d != cyc) begin
                        n_fail++;
                        $display("FAIL sb_flit: got %h at cycle %0d, want %h at cycle %0d", bus.txreqflit, cyc, f, d);
                    end
                end
            end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_missing: got txreqflitv=%b at cycle %0d, want flit %h due %0d",
                         bus.txreqflitv, cyc, exp_q[0], due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic c);
        bus.req_valid  = v;
        bus.txreqlcrdv = c;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_grant(input int i);
        exp_q.push_back(flits[i]);
        due_q.push_back(cyc + 1);
    endtask

    task automatic set_flits();
        qos_t q;
        q = qos_t'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
            flits[i].qos    = q;
            flits[i].tgt_id = 7'($urandom_range(0, 127));
            flits[i].src_id = 7'($urandom_range(0, 127));
            flits[i].txn_id = 8'($urandom_range(0, 255));
            flits[i].opcode = 6'($urandom_range(0, 63));
            flits[i].addr   = {16'($urandom_range(0, 65535)), 32'($urandom)};
            bus.req_flit[i] = flits[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0000, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic give_credits(input int n);
        for (int k = 0; k < n; k++) begin
            drive(4'b0000, 1'b1);
            next_cycle();
        end
    endtask

    task automatic test_reset();
        set_flits();
        reset = 1'b1;
        drive(4'b1111, 1'b1);
        next_cycle();
        next_cycle();
        n_checks++;
        if (bus.txreqflitv !== 1'b0 || bus.txreqflit !== '0) begin
            n_fail++;
            $display("FAIL reset_flit: got v=%b flit=%h, want v=0 flit=0", bus.txreqflitv, bus.txreqflit);
        end
        n_checks++;
        if (bus.crd_cnt !== 4'd0 || bus.crd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_crd: got cnt=%0d ovf=%b, want cnt=0 ovf=0", bus.crd_cnt, bus.crd_ovf);
        end
        n_checks++;
        if (bus.req_ready !== 4'b0000 || bus.txreqflitpend !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got ready=%b pend=%b, want ready=0000 pend=1", bus.req_ready, bus.txreqflitpend);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        drive(4'b0000, 1'b0);
        next_cycle();
        n_checks++;
        if (bus.crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_no_crd: got cnt=%0d, want 0", bus.crd_cnt);
        end
    endtask

    task automatic test_basic_rr();
        logic [3:0] exp_g [3];
        int         exp_i [3];
        int         exp_c [3];
        exp_g = '{4'b0001, 4'b0100, 4'b0001};
        exp_i = '{0, 2, 0};
        exp_c = '{3, 2, 1};
        set_flits();
        give_credits(3);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0101, 1'b0);
            n_checks++;
            if (bus.req_ready !== exp_g[k] || bus.crd_cnt !== 4'(exp_c[k])) begin
                n_fail++;
                $display("FAIL basic_grant%0d: got ready=%b cnt=%0d, want ready=%b cnt=%0d",
                         k, bus.req_ready, bus.crd_cnt, exp_g[k], exp_c[k]);
            end
            expect_grant(exp_i[k]);
            next_cycle();
        end
        drive(4'b0101, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0000 || bus.crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_drained: got ready=%b cnt=%0d, want ready=0000 cnt=0", bus.req_ready, bus.crd_cnt);
        end
        drive(4'b0000, 1'b0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_credit_wake();
        set_flits();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0010, 1'b0);
            n_checks++;
            if (bus.req_ready !== 4'b0000 || bus.txreqflitpend !== 1'b1) begin
                n_fail++;
                $display("FAIL wake_wait%0d: got ready=%b pend=%b, want ready=0000 pend=1", k, bus.req_ready, bus.txreqflitpend);
            end
            next_cycle();
        end
        drive(4'b0010, 1'b1);
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL wake_no_bypass: got ready=%b, want 0000", bus.req_ready);
        end
        next_cycle();
        drive(4'b0010, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0010 || bus.crd_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL wake_grant: got ready=%b cnt=%0d, want ready=0010 cnt=1", bus.req_ready, bus.crd_cnt);
        end
        expect_grant(1);
        next_cycle();
        drive(4'b0000, 1'b0);
        n_checks++;
        if (bus.txreqflitv !== 1'b1 || bus.txreqflit.txn_id !== flits[1].txn_id) begin
            n_fail++;
            $display("FAIL wake_txnid: got v=%b txn=%h, want v=1 txn=%h", bus.txreqflitv, bus.txreqflit.txn_id, flits[1].txn_id);
        end
        n_checks++;
        if (bus.crd_cnt !== 4'd0 || bus.txreqflitpend !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_after: got cnt=%0d pend=%b, want cnt=0 pend=0", bus.crd_cnt, bus.txreqflitpend);
        end
        next_cycle();
    endtask

    task automatic test_overflow();
        do_reset();
        give_credits(15);
        drive(4'b0000, 1'b1);
        n_checks++;
        if (bus.crd_cnt !== 4'd15 || bus.crd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b, want cnt=15 ovf=0", bus.crd_cnt, bus.crd_ovf);
        end
        next_cycle();
        drive(4'b0000, 1'b0);
        n_checks++;
        if (bus.crd_cnt !== 4'd15 || bus.crd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got cnt=%0d ovf=%b, want cnt=15 ovf=1", bus.crd_cnt, bus.crd_ovf);
        end
        next_cycle();
        next_cycle();
        n_checks++;
        if (bus.crd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b, want 1", bus.crd_ovf);
        end
        do_reset();
        n_checks++;
        if (bus.crd_ovf !== 1'b0 || bus.crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_reset_clear: got cnt=%0d ovf=%b, want cnt=0 ovf=0", bus.crd_cnt, bus.crd_ovf);
        end
        set_flits();
        give_credits(15);
        drive(4'b0001, 1'b1);
        n_checks++;
        if (bus.req_ready !== 4'b0001 || bus.crd_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL full_both_grant: got ready=%b cnt=%0d, want ready=0001 cnt=15", bus.req_ready, bus.crd_cnt);
        end
        expect_grant(0);
        next_cycle();
        drive(4'b0000, 1'b0);
        n_checks++;
        if (bus.crd_cnt !== 4'd15 || bus.crd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_both_cnt: got cnt=%0d ovf=%b, want cnt=15 ovf=0", bus.crd_cnt, bus.crd_ovf);
        end
        next_cycle();
    endtask

    task automatic test_qos();
        logic [3:0] g0;
        logic [3:0] g1;
        int         i0;
        int         i1;
        do_reset();
        set_flits();
        flits[0].qos = 4'd2;
        flits[1].qos = 4'd9;
        flits[2].qos = 4'd0;
        flits[3].qos = 4'd9;
        for (int i = 0; i < 4; i++) bus.req_flit[i] = flits[i];
`ifdef HNF_TXREQ_QOS_EN
        g0 = 4'b0010; i0 = 1;
        g1 = 4'b1000; i1 = 3;
`else
        g0 = 4'b0001; i0 = 0;
        g1 = 4'b0010; i1 = 1;
`endif
        give_credits(2);
        drive(4'b1011, 1'b0);
        n_checks++;
        if (bus.req_ready !== g0) begin
            n_fail++;
            $display("FAIL qos_first: got ready=%b, want %b", bus.req_ready, g0);
        end
        expect_grant(i0);
        next_cycle();
        drive(4'b1011, 1'b0);
        n_checks++;
        if (bus.req_ready !== g1) begin
            n_fail++;
            $display("FAIL qos_second: got ready=%b, want %b", bus.req_ready, g1);
        end
        expect_grant(i1);
        next_cycle();
        drive(4'b1011, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0000 || bus.crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL qos_drained: got ready=%b cnt=%0d, want ready=0000 cnt=0", bus.req_ready, bus.crd_cnt);
        end
        drive(4'b0000, 1'b0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_flits();
        give_credits(6);
        drive(4'b0001, 1'b0);
        expect_grant(0);
        next_cycle();
        reset = 1'b1;
        drive(4'b0000, 1'b0);
        n_checks++;
        if (bus.crd_cnt !== 4'd5 || bus.txreqflitv !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before: got cnt=%0d v=%b, want cnt=5 v=1", bus.crd_cnt, bus.txreqflitv);
        end
        next_cycle();
        n_checks++;
        if (bus.crd_cnt !== 4'd0 || bus.txreqflitv !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got cnt=%0d v=%b, want cnt=0 v=0", bus.crd_cnt, bus.txreqflitv);
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(4'b1111, 1'b0);
            n_checks++;
            if (bus.req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_nogrant%0d: got ready=%b, want 0000", k, bus.req_ready);
            end
            next_cycle();
        end
        drive(4'b1111, 1'b1);
        next_cycle();
        drive(4'b1111, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0001 || bus.crd_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_regrant: got ready=%b cnt=%0d, want ready=0001 cnt=1", bus.req_ready, bus.crd_cnt);
        end
        expect_grant(0);
        next_cycle();
        drive(4'b0000, 1'b0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        do_reset();
        set_flits();
        give_credits(10);
        for (int k = 0; k < 8; k++) begin
            g = 4'b0001 << (k % 4);
            drive(4'b1111, 1'b1);
            n_checks++;
            if (bus.req_ready !== g || bus.crd_cnt !== 4'd10) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: got ready=%b cnt=%0d, want ready=%b cnt=10", k, bus.req_ready, bus.crd_cnt, g);
            end
            if (k >= 1) begin
                n_checks++;
                if (bus.txreqflitv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_valid%0d: got v=%b, want 1", k, bus.txreqflitv);
                end
            end
            expect_grant(k % 4);
            next_cycle();
        end
        drive(4'b0000, 1'b0);
        next_cycle();
        n_checks++;
        if (bus.txreqflitv !== 1'b0 || bus.crd_cnt !== 4'd10) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b cnt=%0d, want v=0 cnt=10", bus.txreqflitv, bus.crd_cnt);
        end
        next_cycle();
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.txreqlcrdv = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_flit[i] = '0;
        test_reset();
        test_basic_rr();
        test_credit_wake();
        test_overflow();
        test_qos();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d undelivered flits, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: got no completion by %0t, want completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
